// File: rtl/lea_enc_round.sv
// lea_enc_round: one LEA encryption round computed over three cycles with a
// single shared 32-bit adder (one lane per cycle), valid/ready on both sides.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset (aborts any round in flight)
//   in_valid  upstream offers x_in/rk_in
//   in_ready  high only in IDLE
//   x_in      state, X[i] = x_in[32i+31:32i]
//   rk_in     round key, RK[j] = rk_in[32j+31:32j]
//   out_valid high only in DONE
//   out_ready downstream accepts x_out
//   x_out     next state {Y3,Y2,Y1,Y0}
//   busy      high whenever not IDLE
module lea_enc_round (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] x_in,
    input  logic [191:0] rk_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] x_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    state_e         state_q, state_d;
    logic [1:0]     lane_q;
    logic [127:0]   xcap_q;
    logic [191:0]   rkcap_q;
    logic [127:0]   xout_q;

    logic [31:0]    op_a, op_b, sum, lane_res;

    // Shared adder: operand pair and output rotation chosen by the lane counter.
    always_comb begin
        op_a     = '0;
        op_b     = '0;
        lane_res = '0;
        case (lane_q)
            2'd0: begin
                op_a = xcap_q[31:0]   ^ rkcap_q[31:0];
                op_b = xcap_q[63:32]  ^ rkcap_q[63:32];
            end
            2'd1: begin
                op_a = xcap_q[63:32]  ^ rkcap_q[95:64];
                op_b = xcap_q[95:64]  ^ rkcap_q[127:96];
            end
            default: begin
                op_a = xcap_q[95:64]  ^ rkcap_q[159:128];
                op_b = xcap_q[127:96] ^ rkcap_q[191:160];
            end
        endcase
        sum = op_a + op_b;
        case (lane_q)
            2'd0:    lane_res = {sum[22:0], sum[31:23]};   // ROL9
            2'd1:    lane_res = {sum[4:0],  sum[31:5]};    // ROR5
            default: lane_res = {sum[2:0],  sum[31:3]};    // ROR3
        endcase
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_d = CALC;
            end
            CALC: begin
                if (lane_q == 2'd2) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= '0;
            xcap_q  <= '0;
            rkcap_q <= '0;
            xout_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        xcap_q  <= x_in;
                        rkcap_q <= rk_in;
                        lane_q  <= '0;
                    end
                end
                CALC: begin
                    lane_q <= lane_q + 2'd1;
                    case (lane_q)
                        2'd0: xout_q[31:0]  <= lane_res;
                        2'd1: xout_q[63:32] <= lane_res;
                        default: begin
                            xout_q[95:64]  <= lane_res;
                            xout_q[127:96] <= xcap_q[31:0];
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign x_out = xout_q;

endmodule
